// File: rtl/hswish_out_packer_if.sv
// Output word bus of the h-swish packer: ready/valid stream of packed int8 lanes.
//   m_data  : LANES bytes, lane 0 in bits [7:0]
//   m_keep  : per-lane valid bits
//   m_last  : word closes a frame
//   m_valid : word available
//   m_ready : consumer accepts the word
// master drives data/keep/last/valid and samples ready; slave is the consumer.
interface hswish_out_packer_if #(
  parameter int unsigned LANES = 4
) ();
  logic [8*LANES-1:0] m_data;
  logic [LANES-1:0]   m_keep;
  logic               m_last;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output m_data,
    output m_keep,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_keep,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/hswish_out_packer.sv
// Receive end of the h-swish activation stream. Requantizes signed Q(WIDTH).(FRAC) samples
// to int8 (round-half-up, saturating), packs LANES bytes per word, buffers words in a small
// FIFO and presents them on a ready/valid master port. The last word of a frame is tagged.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : shared pipeline enable; a sample is accepted only when en & valid_in
//   data_in    : signed activation sample
//   valid_in   : sample valid
//   in_stall   : upstream must drop en (FIFO has at most one free slot)
//   m          : packed word stream (master modport)
//   sat_count  : saturating count of clamp events
//   overflow   : sticky, a word was dropped because the FIFO was full
module hswish_out_packer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned OUT_FRAC   = 4,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  output logic                   in_stall,
  hswish_out_packer_if.master    m,
  output logic [15:0]            sat_count,
  output logic                   overflow
);
  localparam int unsigned SH     = FRAC - OUT_FRAC;
  localparam int unsigned LaneW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ElemW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [WIDTH:0] RoundC = (WIDTH+1)'(1 << (SH - 1));
  localparam logic signed [WIDTH:0] QMax   = (WIDTH+1)'(127);
  localparam logic signed [WIDTH:0] QMin   = -(WIDTH+1)'(128);

  logic                   accept;
  logic signed [WIDTH:0]  t, q;
  logic                   sat_hi, sat_lo;
  logic [7:0]             q8;

  logic [LaneW-1:0]       lane_q;
  logic [ElemW-1:0]       elem_q;
  logic [8*LANES-1:0]     word_q, word_next;
  logic [LANES-1:0]       keep_q, keep_next;
  logic                   lane_last, elem_last, push;

  logic [8*LANES-1:0]     mem_data [FIFO_DEPTH];
  logic [LANES-1:0]       mem_keep [FIFO_DEPTH];
  logic                   mem_last [FIFO_DEPTH];
  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   full, pop, wr_en, drop;

  assign accept = valid_in & en;

  // Requantize: one extra bit keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    t      = $signed({data_in[WIDTH-1], data_in}) + RoundC;
    q      = t >>> SH;
    sat_hi = q > QMax;
    sat_lo = q < QMin;
    q8     = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : q[7:0]);
  end

  always_comb begin
    word_next = word_q;
    keep_next = keep_q;
    word_next[int'(lane_q)*8 +: 8] = q8;
    keep_next[lane_q]              = 1'b1;
  end

  assign lane_last = (lane_q == LaneW'(LANES - 1));
  assign elem_last = (elem_q == ElemW'(FRAME_LEN - 1));
  assign push      = accept & (lane_last | elem_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q    <= '0;
      elem_q    <= '0;
      word_q    <= '0;
      keep_q    <= '0;
      sat_count <= '0;
    end else if (accept) begin
      lane_q <= (lane_last | elem_last) ? '0 : lane_q + 1'b1;
      elem_q <= elem_last ? '0 : elem_q + 1'b1;
      if (push) begin
        word_q <= '0;
        keep_q <= '0;
      end else begin
        word_q <= word_next;
        keep_q <= keep_next;
      end
      if ((sat_hi | sat_lo) && sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

  // Word FIFO. When full, a push is still taken if the head leaves on the same edge.
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop   = (count_q != '0) & m.m_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= word_next;
      mem_keep[wr_ptr_q] <= keep_next;
      mem_last[wr_ptr_q] <= elem_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (wr_en) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset, so outputs are forced to zero while the FIFO is empty.
  always_comb begin
    m.m_valid = (count_q != '0);
    m.m_data  = m.m_valid ? mem_data[rd_ptr_q] : '0;
    m.m_keep  = m.m_valid ? mem_keep[rd_ptr_q] : '0;
    m.m_last  = m.m_valid ? mem_last[rd_ptr_q] : 1'b0;
  end

  assign in_stall = (count_q >= CntW'(FIFO_DEPTH - 1));
endmodule

// File: tb/tb_hswish_out_packer.sv
module tb_hswish_out_packer;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, valid_a, en_b, valid_b;
  logic [15:0] data_a, data_b;
  logic        ready_a, ready_b;
  logic        stall_a, stall_b;
  logic [15:0] sat_a, sat_b;
  logic        ovf_a, ovf_b;

  int tests = 0;
  int fails = 0;
  word_t q_a[$];
  word_t q_b[$];

  int          idx, lane;
  logic [31:0] cur, head;

  hswish_out_packer_if ifa ();
  hswish_out_packer_if ifb ();
  assign ifa.m_ready = ready_a;
  assign ifb.m_ready = ready_b;

  hswish_out_packer u_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en_a),
    .data_in   (data_a),
    .valid_in  (valid_a),
    .in_stall  (stall_a),
    .m         (ifa),
    .sat_count (sat_a),
    .overflow  (ovf_a)
  );

  hswish_out_packer #(.FRAME_LEN(6)) u_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en_b),
    .data_in   (data_b),
    .valid_in  (valid_b),
    .in_stall  (stall_b),
    .m         (ifb),
    .sat_count (sat_b),
    .overflow  (ovf_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: round-half-up of x/16 with int8 clamp.
  function automatic logic [7:0] quant(input logic [15:0] x);
    int v, r;
    v = int'($signed(x));
    r = (v + 8) >>> 4;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // Scoreboard monitors: a handshake seen at the falling edge completes on the next rise.
  always @(negedge clk) begin
    if (!rst && ifa.m_valid && ifa.m_ready) begin
      word_t e;
      tests++;
      assert (q_a.size() != 0) else begin
        fails++;
        $error("FAIL a_unexpected_word observed=%0h expected=none", ifa.m_data);
      end
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_data", ifa.m_data, e.d);
        check("a_keep", 32'(ifa.m_keep), 32'(e.k));
        check("a_last", 32'(ifa.m_last), 32'(e.l));
      end
    end
    if (!rst && ifb.m_valid && ifb.m_ready) begin
      word_t e;
      tests++;
      assert (q_b.size() != 0) else begin
        fails++;
        $error("FAIL b_unexpected_word observed=%0h expected=none", ifb.m_data);
      end
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_data", ifb.m_data, e.d);
        check("b_keep", 32'(ifb.m_keep), 32'(e.k));
        check("b_last", 32'(ifb.m_last), 32'(e.l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [15:0] d);
    data_a = d; valid_a = 1'b1; en_a = 1'b1;
    tick();
    valid_a = 1'b0; en_a = 1'b0;
  endtask

  task automatic accept_b(input logic [15:0] d);
    data_b = d; valid_b = 1'b1; en_b = 1'b1;
    tick();
    valid_b = 1'b0; en_b = 1'b0;
  endtask

  task automatic drain_a();
    for (int c = 0; c < 60; c++) begin
      if (q_a.size() == 0 && !ifa.m_valid) break;
      tick();
    end
    check("a_drained", 32'(q_a.size()) | 32'(ifa.m_valid), 32'd0);
  endtask

  task automatic drain_b();
    for (int c = 0; c < 60; c++) begin
      if (q_b.size() == 0 && !ifb.m_valid) break;
      tick();
    end
    check("b_drained", 32'(q_b.size()) | 32'(ifb.m_valid), 32'd0);
  endtask

  // One cycle of the backpressure test: upstream obeys in_stall.
  task automatic step5();
    en_a    = !stall_a && (idx < 16);
    valid_a = 1'b1;
    data_a  = 16'h0100 + 16'(idx * 64);
    if (en_a) begin
      cur[8*lane +: 8] = quant(data_a);
      lane++;
      if (lane == 4) begin
        q_a.push_back({cur, 4'hF, 1'b0});
        cur  = '0;
        lane = 0;
      end
      idx++;
    end
    tick();
    valid_a = 1'b0; en_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en_a = 0; valid_a = 0; data_a = '0; ready_a = 1'b1;
    en_b = 0; valid_b = 0; data_b = '0; ready_b = 1'b1;
    repeat (2) tick();
    check("rst_valid",    32'(ifa.m_valid), 32'd0);
    check("rst_data",     ifa.m_data,       32'd0);
    check("rst_keep",     32'(ifa.m_keep),  32'd0);
    check("rst_last",     32'(ifa.m_last),  32'd0);
    check("rst_sat",      32'(sat_a),       32'd0);
    check("rst_overflow", 32'(ovf_a),       32'd0);
    check("rst_stall",    32'(stall_a),     32'd0);
    rst = 1'b0;
    tick();

    // 1: pack
    q_a.push_back({32'h00F01810, 4'hF, 1'b0});
    accept_a(16'h0100);
    accept_a(16'h0180);
    accept_a(16'hFF00);
    check("t1_valid_before", 32'(ifa.m_valid), 32'd0);
    accept_a(16'h0000);
    check("t1_valid_after", 32'(ifa.m_valid), 32'd1);
    check("t1_data", ifa.m_data, 32'h00F01810);
    tick();

    // 2: saturation
    q_a.push_back({32'h807F807F, 4'hF, 1'b0});
    accept_a(16'h7FFF);
    accept_a(16'h8000);
    accept_a(16'h07F0);
    accept_a(16'hF800);
    tick();
    check("t2_sat_count", 32'(sat_a), 32'd2);

    // 3: rounding
    q_a.push_back({32'hFF000001, 4'hF, 1'b0});
    accept_a(16'h0008);
    accept_a(16'h0007);
    accept_a(16'hFFF8);
    accept_a(16'hFFF7);
    tick();
    check("t3_sat_count", 32'(sat_a), 32'd2);
    drain_a();

    // 4: frame end on the FRAME_LEN=6 instance; the 7th sample starts lane 0
    q_b.push_back({32'h01010101, 4'hF, 1'b0});
    q_b.push_back({32'h00000101, 4'h3, 1'b1});
    q_b.push_back({32'h02020202, 4'hF, 1'b0});
    for (int i = 0; i < 6; i++) accept_b(16'h0010);
    for (int i = 0; i < 4; i++) accept_b(16'h0020);
    drain_b();

    // 5: backpressure with en = ~in_stall
    ready_a = 1'b0; idx = 0; lane = 0; cur = '0;
    for (int c = 0; c < 20; c++) step5();
    head = ifa.m_data;
    repeat (3) tick();
    check("t5_accepted_stalled", 32'(idx),     32'd12);
    check("t5_stall",            32'(stall_a), 32'd1);
    check("t5_head_stable",      ifa.m_data,   head);
    check("t5_head_value",       ifa.m_data,   32'h1C181410);
    check("t5_overflow",         32'(ovf_a),   32'd0);
    ready_a = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (idx >= 16) break;
      step5();
    end
    check("t5_accepted_all", 32'(idx), 32'd16);
    drain_a();
    check("t5_overflow_end", 32'(ovf_a), 32'd0);

    // 6: reset mid-frame, then forced overflow
    accept_a(16'h0100);
    accept_a(16'h0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid_after_rst", 32'(ifa.m_valid), 32'd0);
    check("t6_sat_after_rst",   32'(sat_a),       32'd0);
    q_a.push_back({32'h40302010, 4'hF, 1'b0});
    accept_a(16'h0100);
    accept_a(16'h0200);
    accept_a(16'h0300);
    accept_a(16'h0400);
    drain_a();
    ready_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      b = 8'((k + 1) * 16);
      if (k < 4) q_a.push_back({{4{b}}, 4'hF, 1'b0});
      for (int j = 0; j < 4; j++) accept_a(16'((k + 1) * 256));
      if (k == 3) begin
        check("t6_overflow_before", 32'(ovf_a),   32'd0);
        check("t6_stall_full",      32'(stall_a), 32'd1);
      end
    end
    check("t6_overflow_after", 32'(ovf_a), 32'd1);
    ready_a = 1'b1;
    drain_a();
    check("t6_overflow_sticky", 32'(ovf_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
